// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_ID_WIDTH = 3;

    // Index width that never collapses to zero bits.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                    valid;
        logic [MAX_ID_WIDTH-1:0] id;
        logic                    we;
    } resp_t;

endpackage

// File: rtl/data_mem_arbiter_rr_picker.sv
// Rotating priority picker: first valid bit at or after ptr_i, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [ID_WIDTH-1:0] idx_o,
    output logic                any_o
);

    always_comb begin
        logic [ID_WIDTH-1:0] slot;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        slot    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            slot = ID_WIDTH'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && valid_i[slot]) begin
                any_o         = 1'b1;
                grant_o[slot] = 1'b1;
                idx_o         = slot;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory port, with
// an owner lock for atomic read-modify-write and a forced release timeout.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = id_width(NUM_REQ),
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOCK_MAX   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             resp_valid,
    output logic [ID_WIDTH-1:0]              resp_id,
    output logic                             resp_we,
    output logic [DATA_WIDTH-1:0]            resp_rdata,
    output logic                             lock_timeout,
    output logic                             mem_we,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int unsigned CNT_W = id_width(LOCK_MAX);

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  lock_active_q, lock_active_d;
    logic [ID_WIDTH-1:0]   lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic                  lock_timeout_q, lock_timeout_d;
    resp_t                 resp_q, resp_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] last_wdata_q, last_wdata_d;

    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   win_idx;
    logic                  win;
    logic                  unused_resp_id_bits;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // While locked only the owner may compete; nothing is granted in reset.
    always_comb begin
        eligible = req_valid;
        if (rst) begin
            eligible = '0;
        end else if (lock_active_q) begin
            eligible = req_valid & (NUM_REQ'(1) << lock_owner_q);
        end
    end

    rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid_i (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (win)
    );

    assign req_ready = grant;

    // Idle cycles park the address bus on the previous winner's access.
    always_comb begin
        mem_we    = win & req_we[win_idx];
        mem_addr  = win ? addr_arr[win_idx]  : last_addr_q;
        mem_wdata = win ? wdata_arr[win_idx] : last_wdata_q;
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        lock_active_d  = lock_active_q;
        lock_owner_d   = lock_owner_q;
        lock_cnt_d     = lock_cnt_q;
        lock_timeout_d = 1'b0;
        last_addr_d    = mem_addr;
        last_wdata_d   = mem_wdata;
        resp_d.valid   = win;
        resp_d.id      = MAX_ID_WIDTH'(win_idx);
        resp_d.we      = mem_we;

        if (win && !lock_active_q) begin
            rr_ptr_d = (win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + ID_WIDTH'(1);
        end

        // Forced release takes precedence over anything the owner does.
        if (lock_active_q && lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            lock_active_d  = 1'b0;
            lock_cnt_d     = '0;
            lock_timeout_d = 1'b1;
        end else if (win && req_lock[win_idx]) begin
            lock_active_d = 1'b1;
            lock_owner_d  = win_idx;
            lock_cnt_d    = lock_active_q ? lock_cnt_q + CNT_W'(1) : '0;
        end else if (win && lock_active_q) begin
            lock_active_d = 1'b0;
            lock_cnt_d    = '0;
        end else if (lock_active_q) begin
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q       <= '0;
            lock_active_q  <= 1'b0;
            lock_owner_q   <= '0;
            lock_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
            resp_q         <= '0;
            last_addr_q    <= '0;
            last_wdata_q   <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            lock_active_q  <= lock_active_d;
            lock_owner_q   <= lock_owner_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_timeout_q <= lock_timeout_d;
            resp_q         <= resp_d;
            last_addr_q    <= last_addr_d;
            last_wdata_q   <= last_wdata_d;
        end
    end

    assign resp_valid          = resp_q.valid;
    assign resp_id             = resp_q.id[ID_WIDTH-1:0];
    assign resp_we             = resp_q.we;
    assign resp_rdata          = mem_rdata;
    assign lock_timeout        = lock_timeout_q;
    assign unused_resp_id_bits = ^resp_q.id;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vectors plus random traffic
// compared every cycle against a cycle-level reference model.
module tb_data_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LM = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid, req_we, req_lock, req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic              resp_valid, resp_we, lock_timeout, mem_we;
    logic [IW-1:0]     resp_id;
    logic [DW-1:0]     resp_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]     mem_addr;

    data_mem_arbiter #(
        .NUM_REQ(NR), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_we(resp_we),
        .resp_rdata(resp_rdata), .lock_timeout(lock_timeout),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0: return 32'h11;
            1: return 32'h22;
            2: return 32'h33;
            3: return 32'h44;
            default: return 32'hA500_0000 | 32'(i);
        endcase
    endfunction

    // Memory: one-cycle synchronous read, read-first on a write.
    bit [31:0] mem [1024];
    bit        memw[1024];
    always @(posedge clk) begin
        mem_rdata <= memw[mem_addr[11:2]] ? mem[mem_addr[11:2]] : init_word(int'(mem_addr[11:2]));
        if (mem_we) begin
            mem[mem_addr[11:2]]  <= mem_wdata;
            memw[mem_addr[11:2]] <= 1'b1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_ptr, m_own, m_cnt;
    bit          m_to;
    bit          p_v, p_we;
    int          p_id;
    logic [31:0] p_rd;
    logic [31:0] m_last;
    bit          m_last_v;
    bit [31:0]   mm [1024];
    bit          mmw[1024];

    function automatic logic [31:0] a_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction
    function automatic logic [31:0] d_of(input int i);
        return req_wdata[i*DW +: DW];
    endfunction

    function automatic int model_grant();
        if (m_own >= 0) return req_valid[m_own] ? m_own : -1;
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_own = -1; m_cnt = 0; m_to = 0;
        p_v = 0; p_we = 0; p_id = 0; p_rd = '0; m_last_v = 0; m_last = '0;
    endtask

    task automatic model_check();
        int g;
        logic [NR-1:0] er;
        if (rst) begin
            chk("rst_ready", 64'(req_ready), 0);
            chk("rst_mem_we", 64'(mem_we), 0);
            chk("rst_resp_valid", 64'(resp_valid), 0);
            chk("rst_resp_id", 64'(resp_id), 0);
            chk("rst_lock_timeout", 64'(lock_timeout), 0);
            return;
        end
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("m_ready", 64'(req_ready), 64'(er));
        chk("m_mem_we", 64'(mem_we), 64'((g >= 0) ? req_we[g] : 1'b0));
        if (g >= 0) begin
            chk("m_mem_addr", 64'(mem_addr), 64'(a_of(g)));
            if (req_we[g]) chk("m_mem_wdata", 64'(mem_wdata), 64'(d_of(g)));
        end else if (m_last_v) begin
            chk("m_mem_addr_hold", 64'(mem_addr), 64'(m_last));
        end
        chk("m_resp_valid", 64'(resp_valid), 64'(p_v));
        if (p_v) begin
            chk("m_resp_id", 64'(resp_id), 64'(p_id));
            chk("m_resp_we", 64'(resp_we), 64'(p_we));
            if (!p_we) chk("m_resp_rdata", 64'(resp_rdata), 64'(p_rd));
        end
        chk("m_lock_timeout", 64'(lock_timeout), 64'(m_to));
    endtask

    task automatic model_step();
        int g, idx;
        bit locked;
        if (rst) begin
            model_reset();
            return;
        end
        g      = model_grant();
        locked = (m_own >= 0);
        p_v    = (g >= 0);
        p_id   = (g >= 0) ? g : 0;
        p_we   = (g >= 0) ? req_we[g] : 1'b0;
        if (g >= 0) begin
            idx      = int'(a_of(g) >> 2) % 1024;
            p_rd     = mmw[idx] ? mm[idx] : init_word(idx);
            if (req_we[g]) begin
                mm[idx]  = d_of(g);
                mmw[idx] = 1'b1;
            end
            m_last   = a_of(g);
            m_last_v = 1'b1;
            if (!locked) m_ptr = (g + 1) % NR;
        end
        m_to = 0;
        if (locked && m_cnt == LM - 1) begin
            m_own = -1; m_cnt = 0; m_to = 1;
        end else if (g >= 0 && req_lock[g]) begin
            m_cnt = locked ? m_cnt + 1 : 0;
            m_own = g;
        end else if (g >= 0 && locked) begin
            m_own = -1; m_cnt = 0;
        end else if (locked) begin
            m_cnt++;
        end
    endtask

    task automatic neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_lock[i]           = lk;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    typedef struct {
        logic [NR-1:0] rdy;
        bit            rv;
        int            rid;
        logic [31:0]   rd;
    } rr_vec_t;

    rr_vec_t tbl[8];
    int      n_to, to_pos;

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 0, 32'h00};
        tbl[1] = '{4'b0010, 1'b1, 0, 32'h11};
        tbl[2] = '{4'b0100, 1'b1, 1, 32'h22};
        tbl[3] = '{4'b1000, 1'b1, 2, 32'h33};
        tbl[4] = '{4'b0001, 1'b1, 3, 32'h44};
        tbl[5] = '{4'b0010, 1'b1, 0, 32'h11};
        tbl[6] = '{4'b0100, 1'b1, 1, 32'h22};
        tbl[7] = '{4'b1000, 1'b1, 2, 32'h33};

        req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        model_reset();
        #1 rst = 1'b1;

        // Reset holds off every grant even with all requesters writing.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 1'b0, 32'(4 * i), 32'hBAD0_0000 | 32'(i));
        repeat (3) begin
            neg();
            chk("reset_ready", 64'(req_ready), 0);
            chk("reset_mem_we", 64'(mem_we), 0);
            chk("reset_resp_valid", 64'(resp_valid), 0);
            adv();
        end
        req_we = '0;
        rst    = 1'b0;

        // All four reading continuously: strict rotation with tagged responses.
        for (int i = 0; i < 8; i++) begin
            neg();
            chk("rr_ready", 64'(req_ready), 64'(tbl[i].rdy));
            chk("rr_resp_valid", 64'(resp_valid), 64'(tbl[i].rv));
            if (tbl[i].rv) begin
                chk("rr_resp_id", 64'(resp_id), 64'(tbl[i].rid));
                chk("rr_resp_rdata", 64'(resp_rdata), 64'(tbl[i].rd));
            end
            adv();
        end

        // Write then read-back of the same word on consecutive cycles.
        req_valid = '0;
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
        neg();
        chk("wr_ready", 64'(req_ready), 64'(4'b0010));
        chk("wr_mem_we", 64'(mem_we), 1);
        adv();
        req_we[1] = 1'b0;
        neg();
        chk("wr_ack_valid", 64'(resp_valid), 1);
        chk("wr_ack_we", 64'(resp_we), 1);
        chk("wr_ack_id", 64'(resp_id), 1);
        adv();
        req_valid = '0;
        neg();
        chk("rd_back_we", 64'(resp_we), 0);
        chk("rd_back_data", 64'(resp_rdata), 64'(32'hDEAD_BEEF));
        adv();

        // Locked read-modify-write by requester 2 excludes 0 and 3.
        set_req(2, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        neg();
        chk("lk_rd_ready", 64'(req_ready), 64'(4'b0100));
        adv();
        set_req(2, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(3, 1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
        neg();
        chk("lk_others_wait", 64'(req_ready), 0);
        adv();
        set_req(2, 1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_0040);
        neg();
        chk("lk_wr_ready", 64'(req_ready), 64'(4'b0100));
        adv();
        req_valid[2] = 1'b0;
        req_we       = '0;
        neg();
        chk("lk_resume_rr3", 64'(req_ready), 64'(4'b1000));
        adv();

        // Owner goes idle while holding the lock: forced release after LOCK_MAX cycles.
        req_valid = '0;
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
        neg();
        chk("to_lock_ready", 64'(req_ready), 64'(4'b0010));
        adv();
        req_valid = 4'b0001;
        req_lock  = '0;
        n_to      = 0;
        to_pos    = -1;
        for (int c = 0; c < LM + 4; c++) begin
            neg();
            if (lock_timeout) begin
                n_to++;
                if (to_pos < 0) begin
                    to_pos = c;
                    chk("to_grant_req0", 64'(req_ready), 64'(4'b0001));
                end
            end else if (to_pos < 0) begin
                chk("to_locked_wait", 64'(req_ready), 0);
            end
            adv();
        end
        chk("to_pulse_count", 64'(n_to), 1);
        chk("to_pulse_cycle", 64'(to_pos), 64'(LM));

        // Reset while a read response is due drops it.
        req_valid = 4'b0001;
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        neg();
        adv();
        req_valid = '0;
        #1;
        chk("pre_rst_resp_valid", 64'(resp_valid), 1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_drop_resp", 64'(resp_valid), 0);
        neg();
        adv();
        rst = 1'b0;
        repeat (3) begin
            neg();
            chk("post_rst_no_resp", 64'(resp_valid), 0);
            adv();
        end

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            req_valid = NR'($urandom);
            req_we    = NR'($urandom);
            req_lock  = NR'($urandom & $urandom & $urandom);
            for (int i = 0; i < NR; i++) begin
                req_addr[i*AW +: AW]  = 32'($urandom_range(0, 31)) << 2;
                req_wdata[i*DW +: DW] = $urandom;
            end
            neg();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
